dlsc_cpu1_opfetch: RTL and testbench
====================================

// Module: dlsc_cpu1_opfetch
//
// PURPOSE
// Operand-fetch stage directly upstream of dlsc_cpu1_alu. Accepts decoded instructions and reads the register file.
// Resolves operands with forwarding from EX and WB. Detects load-use hazards.
// Presents registered alu_op/alu_signed/in_a/in_b to the ALU through a valid/ready pipeline register.
//
// PARAMETERS
// DEVICE     "GENERIC"  target device; passed to the regfile sub-module
// REGS       32         architectural registers; r0 reads as zero
// REGB       5          register address width; REGS == 2**REGB
//
// PORTS
// clk            in   1     clock
// rst_n          in   1     asynchronous active-low reset
// flush          in   1     discard the EX-register instruction and any offered ID instruction
// id_valid       in   1     decoded instruction offered
// id_ready       out  1     instruction accepted this cycle (id_valid && id_ready)
// id_ra/id_rb    in   REGB  source register addresses
// id_rd          in   REGB  destination register address
// id_use_imm     in   1     in_b := id_imm instead of rb
// id_imm         in   32    immediate (already extended by decode)
// id_alu_op      in   4     ALU op; alu_op[3] selects the shifter
// id_alu_signed  in   1     signed operation
// id_wr_en       in   1     instruction writes rd
// id_is_load     in   1     rd result comes from memory, not the ALU
// ex_valid       out  1     EX register holds a valid instruction
// ex_ready       in   1     downstream consumes the EX register
// ex_alu_op      out  4     to alu_op
// ex_alu_signed  out  1     to alu_signed
// ex_in_a        out  32    to in_a
// ex_in_b        out  32    to in_b
// ex_rd          out  REGB  passed to the downstream stage
// ex_wr_en       out  1     passed to the downstream stage
// ex_is_load     out  1     passed to the downstream stage
// ex_result      in   32    ALU out_d for the instruction in the EX register (combinational return)
// wb_en          in   1     register-file write enable
// wb_addr        in   REGB  register-file write address
// wb_data        in   32    register-file write data
//
// BEHAVIOUR
// - Reset: ex_valid=0; all other ex_* outputs=0; regfile contents undefined except r0 reads 0. id_ready is combinational.
// - advance = !ex_valid || ex_ready.
// - hazard  = ex_valid && ex_is_load && ex_wr_en && ex_rd!=0
//             && (ex_rd==id_ra || (!id_use_imm && ex_rd==id_rb)).
// - id_ready = advance && !hazard && !flush.
// - Clock edge with advance: ex_valid <= id_valid && id_ready. All ex_* fields capture on that handshake only.
// - Bubble: when a load-use hazard stalls ID, ex_valid drops for one cycle.
// - Hold: while ex_valid && !ex_ready, all ex_* outputs stay stable.
// - Flush: ex_valid <= 0 next edge, whatever ex_ready is. Flush has priority over capture.
// - Latency: ID handshake -> ex_valid one cycle later. Throughput is 1/cycle with no hazards.
// - Operand source, per operand, priority high to low. Address 0 always yields 0.
//   1. EX forward: ex_valid && ex_wr_en && !ex_is_load && ex_rd==addr -> ex_result.
//   2. WB forward: wb_en && wb_addr==addr -> wb_data. Covers same-cycle write and read.
//   3. Regfile read.
// - in_b = id_use_imm ? id_imm : resolved rb. rb forwarding and hazard logic ignore rb when id_use_imm=1.
// - Writes to r0 are dropped. A write and a read of the same register in one cycle return the new data.
// - Reset mid-operation: the in-flight EX instruction is lost. The upstream stage must refetch.
//
// STRUCTURE
// - dlsc_cpu1_params.vh: ALU op encodings; REGB default.
// - Sub-module dlsc_cpu1_regfile: REGS x 32, 2 asynchronous read ports, 1 synchronous write port,
//   no reset, r0 forced to zero on read.
// - Forwarding muxes, hazard detection and the EX register live in this module.
//
// TESTING
// 1. Basic issue: r1=5, r2=7 via WB; issue op rd=3 ra=1 rb=2 -> next cycle ex_valid=1, ex_in_a=5, ex_in_b=7.
// 2. EX forward: back-to-back, with the second instruction's ra = first's rd and ex_result=0x1234
//    -> second captures ex_in_a=0x1234 with no stall.
// 3. Load-use: a load to r4 sits in EX; the next instruction reads r4 -> id_ready=0 for one cycle and
//    ex_valid=0 bubble. Then, with wb_en/wb_addr=4/wb_data=0xBEEF, the instruction issues with in_a=0xBEEF.
// 4. Backpressure: ex_ready=0 for 3 cycles -> ex_* stable, id_ready=0. ex_ready=1 -> the next instruction captured.
// 5. r0 and immediate: ra=0 with a WB write to r0 of 0xFFFF_FFFF -> ex_in_a=0.
//    id_use_imm=1, id_imm=0x80 -> ex_in_b=0x80, and an rb load-use match does not stall.
// 6. Flush and reset: flush while ex_valid=1 -> ex_valid=0 next cycle and no capture.
//    rst_n low mid-stream -> ex_valid=0 immediately (asynchronous).

Source files
------------

// File: rtl/dlsc_cpu1_opfetch_pkg.sv
// Shared definitions for the dlsc_cpu1 operand-fetch slice.
//   REGB_DEFAULT : default register address width (32 architectural registers)
//   XLEN         : datapath width
//   alu_op_t     : ALU op encodings; bit 3 selects the shifter
package dlsc_cpu1_opfetch_pkg;

  localparam int unsigned REGB_DEFAULT = 5;
  localparam int unsigned XLEN         = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLT = 4'h5,
    ALU_SLL = 4'h8,
    ALU_SRL = 4'h9,
    ALU_SRA = 4'hA
  } alu_op_t;

endpackage

// File: rtl/dlsc_cpu1_regfile.sv
// Register file: REGS x XLEN, two asynchronous read ports, one synchronous
// write port, no reset. r0 always reads as zero and writes to it are dropped.
//   clk              clock
//   wr_en/addr/data  write port (synchronous)
//   ra_addr/ra_data  read port A (asynchronous)
//   rb_addr/rb_data  read port B (asynchronous)
module dlsc_cpu1_regfile
  import dlsc_cpu1_opfetch_pkg::*;
#(
  parameter     DEVICE = "GENERIC",
  parameter int REGS   = 32,
  parameter int REGB   = 5
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [REGB-1:0] wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [REGB-1:0] ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [REGB-1:0] rb_addr,
  output logic [XLEN-1:0] rb_data
);

  logic [XLEN-1:0] mem [REGS];

  // No device-specific primitive exists yet; every target infers the
  // same distributed memory.
  generate
    if (DEVICE == "GENERIC") begin : g_generic
      always_ff @(posedge clk) begin
        if (wr_en && (wr_addr != '0)) mem[wr_addr] <= wr_data;
      end
    end else begin : g_device
      always_ff @(posedge clk) begin
        if (wr_en && (wr_addr != '0)) mem[wr_addr] <= wr_data;
      end
    end
  endgenerate

  assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/dlsc_cpu1_opfetch.sv
// Operand-fetch stage feeding dlsc_cpu1_alu. Reads the register file,
// forwards from EX and WB, stalls on load-use hazards and presents the
// resolved operands through a valid/ready EX register.
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop the EX instruction and any offered ID instruction
//   id_*                decoded instruction (valid/ready handshake)
//   ex_*                EX register outputs (valid/ready handshake)
//   ex_result           ALU result for the instruction held in EX
//   wb_en/addr/data     register-file write port
module dlsc_cpu1_opfetch
  import dlsc_cpu1_opfetch_pkg::*;
#(
  parameter     DEVICE = "GENERIC",
  parameter int REGS   = 32,
  parameter int REGB   = REGB_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [REGB-1:0] id_ra,
  input  logic [REGB-1:0] id_rb,
  input  logic [REGB-1:0] id_rd,
  input  logic            id_use_imm,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_op,
  input  logic            id_alu_signed,
  input  logic            id_wr_en,
  input  logic            id_is_load,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_signed,
  output logic [XLEN-1:0] ex_in_a,
  output logic [XLEN-1:0] ex_in_b,
  output logic [REGB-1:0] ex_rd,
  output logic            ex_wr_en,
  output logic            ex_is_load,
  input  logic [XLEN-1:0] ex_result,
  input  logic            wb_en,
  input  logic [REGB-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic            advance;
  logic            hazard;
  logic            ex_fwd_ok;
  logic [XLEN-1:0] rf_a, rf_b;
  logic [XLEN-1:0] op_a, op_b;

  dlsc_cpu1_regfile #(
    .DEVICE (DEVICE),
    .REGS   (REGS),
    .REGB   (REGB)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (wb_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data),
    .ra_addr (id_ra),
    .ra_data (rf_a),
    .rb_addr (id_rb),
    .rb_data (rf_b)
  );

  assign advance   = !ex_valid || ex_ready;
  // A load in EX has no result yet; only ALU results may be forwarded.
  assign ex_fwd_ok = ex_valid && ex_wr_en && !ex_is_load;
  assign hazard    = ex_valid && ex_is_load && ex_wr_en && (ex_rd != '0) &&
                     ((ex_rd == id_ra) || (!id_use_imm && (ex_rd == id_rb)));
  assign id_ready  = advance && !hazard && !flush;

  always_comb begin
    op_a = rf_a;
    if (id_ra == '0)                         op_a = '0;
    else if (ex_fwd_ok && (ex_rd == id_ra))  op_a = ex_result;
    else if (wb_en && (wb_addr == id_ra))    op_a = wb_data;
  end

  always_comb begin
    op_b = rf_b;
    if (id_use_imm)                          op_b = id_imm;
    else if (id_rb == '0)                    op_b = '0;
    else if (ex_fwd_ok && (ex_rd == id_rb))  op_b = ex_result;
    else if (wb_en && (wb_addr == id_rb))    op_b = wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_alu_op     <= '0;
      ex_alu_signed <= 1'b0;
      ex_in_a       <= '0;
      ex_in_b       <= '0;
      ex_rd         <= '0;
      ex_wr_en      <= 1'b0;
      ex_is_load    <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      ex_valid <= id_valid && id_ready;
      if (id_valid && id_ready) begin
        ex_alu_op     <= id_alu_op;
        ex_alu_signed <= id_alu_signed;
        ex_in_a       <= op_a;
        ex_in_b       <= op_b;
        ex_rd         <= id_rd;
        ex_wr_en      <= id_wr_en;
        ex_is_load    <= id_is_load;
      end
    end
  end

endmodule

// File: tb/tb_dlsc_cpu1_opfetch.sv
`timescale 1ns/1ps
module tb_dlsc_cpu1_opfetch;

  logic        clk = 1'b0;
  logic        rst_n, flush, id_valid, id_ready;
  logic [4:0]  id_ra, id_rb, id_rd;
  logic        id_use_imm, id_alu_signed, id_wr_en, id_is_load;
  logic [31:0] id_imm;
  logic [3:0]  id_alu_op;
  logic        ex_valid, ex_ready, ex_alu_signed, ex_wr_en, ex_is_load;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_in_a, ex_in_b, ex_result;
  logic [4:0]  ex_rd;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dlsc_cpu1_opfetch #(.DEVICE("GENERIC"), .REGS(32), .REGB(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_ra(id_ra), .id_rb(id_rb), .id_rd(id_rd),
    .id_use_imm(id_use_imm), .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_alu_signed(id_alu_signed), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_op(ex_alu_op),
    .ex_alu_signed(ex_alu_signed), .ex_in_a(ex_in_a), .ex_in_b(ex_in_b), .ex_rd(ex_rd),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  // Reference model state: architectural registers and the expected EX slot.
  typedef struct {
    bit          v;
    logic [3:0]  op;
    logic        s;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        wr, ld;
  } ex_t;

  logic [31:0] rf_m [32];
  ex_t         em;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    flush = 0; id_valid = 0; id_ra = 0; id_rb = 0; id_rd = 0; id_use_imm = 0; id_imm = 0;
    id_alu_op = 0; id_alu_signed = 0; id_wr_en = 0; id_is_load = 0;
    ex_ready = 1; ex_result = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic offer(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                       input logic ld);
    id_valid = 1; id_rd = rd; id_ra = ra; id_rb = rb; id_is_load = ld; id_wr_en = 1;
    id_use_imm = 0; id_imm = 0; id_alu_op = 4'h0; id_alu_signed = 0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_data = d; tick(); wb_en = 0;
  endtask

  function automatic logic [31:0] resolve(input logic [4:0] addr);
    if (addr == 0) return 32'd0;
    if (em.v && em.wr && !em.ld && em.rd == addr) return ex_result;
    if (wb_en && wb_addr == addr) return wb_data;
    return rf_m[addr];
  endfunction

  task automatic test_reset();
    rst_n = 0; set_idle();
    #12;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid actual=%b required=0", ex_valid); end
    total++; if ({ex_in_a, ex_in_b, ex_rd, ex_alu_op} !== 73'd0) begin bad++; $display("FAIL reset_ex_fields actual=%h/%h/%h/%h required=0", ex_in_a, ex_in_b, ex_rd, ex_alu_op); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_id_ready actual=%b required=1", id_ready); end
    @(negedge clk); rst_n = 1; tick();
  endtask

  task automatic test_basic_issue();
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    offer(5'd3, 5'd1, 5'd2, 0);
    tick();
    total++; if ({ex_valid, ex_in_a, ex_in_b, ex_rd} !== {1'b1, 32'd5, 32'd7, 5'd3}) begin bad++;
      $display("FAIL basic_issue actual=%b/%h/%h/%0d required=1/5/7/3", ex_valid, ex_in_a, ex_in_b, ex_rd); end
    id_valid = 0; tick();
  endtask

  task automatic test_ex_forward();
    offer(5'd5, 5'd1, 5'd2, 0);
    tick();
    ex_result = 32'h1234;
    offer(5'd6, 5'd5, 5'd2, 0);
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL exfwd_no_stall actual=%b required=1", id_ready); end
    tick();
    total++; if ({ex_valid, ex_in_a, ex_in_b} !== {1'b1, 32'h1234, 32'd7}) begin bad++;
      $display("FAIL exfwd_operands actual=%b/%h/%h required=1/1234/7", ex_valid, ex_in_a, ex_in_b); end
    id_valid = 0; ex_result = 0; tick();
  endtask

  task automatic test_load_use();
    offer(5'd4, 5'd1, 5'd2, 1);
    tick();
    offer(5'd6, 5'd4, 5'd2, 0);
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL loaduse_stall actual=%b required=0", id_ready); end
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL loaduse_bubble actual=%b required=0", ex_valid); end
    wb_en = 1; wb_addr = 5'd4; wb_data = 32'hBEEF;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL loaduse_release actual=%b required=1", id_ready); end
    tick();
    wb_en = 0;
    total++; if ({ex_valid, ex_in_a} !== {1'b1, 32'hBEEF}) begin bad++;
      $display("FAIL loaduse_wbfwd actual=%b/%h required=1/beef", ex_valid, ex_in_a); end
  endtask

  // Entered with the load-use consumer (in_a=0xBEEF) held in EX.
  task automatic test_backpressure();
    ex_ready = 0;
    offer(5'd7, 5'd1, 5'd2, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL bp_id_ready cycle=%0d actual=%b required=0", i, id_ready); end
      tick();
      total++; if ({ex_valid, ex_in_a, ex_rd} !== {1'b1, 32'hBEEF, 5'd6}) begin bad++;
        $display("FAIL bp_hold cycle=%0d actual=%b/%h/%0d required=1/beef/6", i, ex_valid, ex_in_a, ex_rd); end
    end
    ex_ready = 1;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL bp_release actual=%b required=1", id_ready); end
    tick();
    total++; if ({ex_valid, ex_in_a, ex_rd} !== {1'b1, 32'd5, 5'd7}) begin bad++;
      $display("FAIL bp_next actual=%b/%h/%0d required=1/5/7", ex_valid, ex_in_a, ex_rd); end
  endtask

  task automatic test_r0_imm();
    offer(5'd8, 5'd0, 5'd2, 0);
    wb_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    tick();
    wb_en = 0;
    total++; if ({ex_valid, ex_in_a} !== {1'b1, 32'd0}) begin bad++;
      $display("FAIL r0_zero actual=%b/%h required=1/0", ex_valid, ex_in_a); end
    offer(5'd9, 5'd1, 5'd2, 1);
    tick();
    offer(5'd10, 5'd1, 5'd9, 0);
    id_use_imm = 1; id_imm = 32'h80;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL imm_no_stall actual=%b required=1", id_ready); end
    tick();
    total++; if ({ex_valid, ex_in_a, ex_in_b} !== {1'b1, 32'd5, 32'h80}) begin bad++;
      $display("FAIL imm_operands actual=%b/%h/%h required=1/5/80", ex_valid, ex_in_a, ex_in_b); end
  endtask

  task automatic test_flush_reset();
    flush = 1;
    offer(5'd11, 5'd2, 5'd1, 0);
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL flush_id_ready actual=%b required=0", id_ready); end
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_drop actual=%b required=0", ex_valid); end
    flush = 0;
    tick();
    ex_ready = 0; flush = 1; id_valid = 0;
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_stalled actual=%b required=0", ex_valid); end
    flush = 0; ex_ready = 1;
    offer(5'd12, 5'd1, 5'd2, 0);
    tick();
    id_valid = 0;
    #2 rst_n = 0;
    #1;
    total++; if ({ex_valid, ex_in_a} !== {1'b0, 32'd0}) begin bad++;
      $display("FAIL async_reset actual=%b/%h required=0/0", ex_valid, ex_in_a); end
    @(negedge clk); rst_n = 1; tick();
  endtask

  task automatic test_random(input int n);
    logic adv, hz, rdy;
    ex_t  nxt;
    set_idle();
    @(negedge clk); rst_n = 0; @(negedge clk); rst_n = 1; tick();
    em = '{default: 0};
    for (int r = 1; r < 32; r++) begin
      rf_m[r] = $urandom; wb_write(5'(r), rf_m[r]);
    end
    for (int i = 0; i < n; i++) begin
      id_valid = ($urandom_range(0, 9) < 8);
      id_ra = 5'($urandom_range(0, 7)); id_rb = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      id_use_imm = ($urandom_range(0, 9) < 3); id_imm = $urandom;
      id_alu_op = 4'($urandom); id_alu_signed = 1'($urandom);
      id_wr_en = ($urandom_range(0, 9) < 8); id_is_load = ($urandom_range(0, 9) < 3);
      ex_ready = ($urandom_range(0, 9) < 7); flush = ($urandom_range(0, 19) == 0);
      ex_result = $urandom;
      wb_en = 1'($urandom); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      #1;
      adv = !em.v || ex_ready;
      hz  = em.v && em.ld && em.wr && em.rd != 0 && (em.rd == id_ra || (!id_use_imm && em.rd == id_rb));
      rdy = adv && !hz && !flush;
      total++; if (id_ready !== rdy) begin bad++; $display("FAIL rnd_id_ready cycle=%0d actual=%b required=%b", i, id_ready, rdy); end
      nxt = em;
      if (flush) nxt.v = 0;
      else if (adv) begin
        nxt.v = id_valid && rdy;
        if (id_valid && rdy) begin
          nxt.op = id_alu_op; nxt.s = id_alu_signed; nxt.rd = id_rd; nxt.wr = id_wr_en; nxt.ld = id_is_load;
          nxt.a = resolve(id_ra);
          nxt.b = id_use_imm ? id_imm : resolve(id_rb);
        end
      end
      if (wb_en && wb_addr != 0) rf_m[wb_addr] = wb_data;
      tick();
      em = nxt;
      total++;
      if ({ex_valid, ex_alu_op, ex_alu_signed, ex_in_a, ex_in_b, ex_rd, ex_wr_en, ex_is_load} !==
          {em.v, em.op, em.s, em.a, em.b, em.rd, em.wr, em.ld}) begin
        bad++;
        $display("FAIL rnd_ex cycle=%0d actual=%b/%h/%b/%h/%h/%0d/%b/%b required=%b/%h/%b/%h/%h/%0d/%b/%b", i,
                 ex_valid, ex_alu_op, ex_alu_signed, ex_in_a, ex_in_b, ex_rd, ex_wr_en, ex_is_load,
                 em.v, em.op, em.s, em.a, em.b, em.rd, em.wr, em.ld);
      end
    end
    set_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_issue();
    test_ex_forward();
    test_load_use();
    test_backpressure();
    test_r0_imm();
    test_flush_reset();
    test_random(600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
